// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: translates one integer instruction per handshake
// into ALU op/operands and buffers up to two issued operations ahead of the ALU.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_op,
    output logic [4:0]  rd,
    output logic        illegal
);
    localparam int DEPTH = 2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SRL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;
    localparam logic [3:0] OP_SLT = 4'b1000;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never depends on ready, and in_ready never looks at out_ready.

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic [31:0] shamt;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};
    assign shamt  = {27'b0, instr[24:20]};

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_op;
    logic        dec_ill;

    always_comb begin
        dec_a   = '0;
        dec_b   = '0;
        dec_op  = OP_ADD;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_op = OP_ADD;
                    {F7_ALT,  3'b000}: dec_op = OP_SUB;
                    {F7_BASE, 3'b001}: dec_op = OP_SLL;
                    {F7_BASE, 3'b010}: dec_op = OP_SLT;
                    {F7_BASE, 3'b100}: dec_op = OP_XOR;
                    {F7_BASE, 3'b101}: dec_op = OP_SRL;
                    {F7_ALT,  3'b101}: dec_op = OP_SRA;
                    {F7_BASE, 3'b110}: dec_op = OP_OR;
                    {F7_BASE, 3'b111}: dec_op = OP_AND;
                    default:           dec_ill = 1'b1;
                endcase
            end
            OPC_OPIMM: begin
                dec_a = rs1_data;
                dec_b = imm_i;
                case (funct3)
                    3'b000: dec_op = OP_ADD;
                    3'b010: dec_op = OP_SLT;
                    3'b100: dec_op = OP_XOR;
                    3'b110: dec_op = OP_OR;
                    3'b111: dec_op = OP_AND;
                    3'b001: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE) dec_op = OP_SLL;
                        else                   dec_ill = 1'b1;
                    end
                    3'b101: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE)     dec_op = OP_SRL;
                        else if (funct7 == F7_ALT) dec_op = OP_SRA;
                        else                       dec_ill = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal entries still flow down the pipe, but with neutral operands.
        if (dec_ill) begin
            dec_a  = '0;
            dec_b  = '0;
            dec_op = OP_ADD;
        end
    end

    logic [31:0] q_a   [DEPTH];
    logic [31:0] q_b   [DEPTH];
    logic [3:0]  q_op  [DEPTH];
    logic [4:0]  q_rd  [DEPTH];
    logic        q_ill [DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign in_ready  = !rst && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < DEPTH; i++) begin
                q_a[i]   <= '0;
                q_b[i]   <= '0;
                q_op[i]  <= '0;
                q_rd[i]  <= '0;
                q_ill[i] <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_a[wr_ptr]   <= dec_a;
                q_b[wr_ptr]   <= dec_b;
                q_op[wr_ptr]  <= dec_op;
                q_rd[wr_ptr]  <= instr[11:7];
                q_ill[wr_ptr] <= dec_ill;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign alu_a   = q_a[rd_ptr];
    assign alu_b   = q_b[rd_ptr];
    assign alu_op  = q_op[rd_ptr];
    assign rd      = q_rd[rd_ptr];
    assign illegal = q_ill[rd_ptr];
endmodule
